bp_update_ctrl: RTL
===================

# bp_update_ctrl

Sequencer between the execute-stage branch resolution path and the branch target buffer (BTB) write side. Resolved branches are buffered in a small in-order queue and written into the BTB one per cycle. On request, the block also walks every BTB entry to invalidate it (fence.i / context switch). During that walk, fetch is told to treat every lookup as a miss.

## Interface
Parameters:
- N, 11, BTB index width; the BTB has 2**N entries.
- DEPTH, 4, update queue depth; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- res_valid  in  1  execute stage presents a resolved branch.
- res_ready  out  1  queue can accept an entry; equals (state==RUN) && !full.
- res_pc  in  32  branch instruction address.
- res_target  in  32  resolved target address.
- res_taken  in  1  branch was taken.
- res_mispred  in  1  fetch prediction was wrong.
- flush_req  in  1  single-cycle request to invalidate the whole BTB.
- upd_valid  out  1  BTB write strobe for the queue head.
- upd_pc  out  32  head branch address.
- upd_target  out  32  head target address.
- upd_taken  out  1  head taken bit.
- upd_mispred  out  1  head mispredict bit.
- inv_valid  out  1  BTB entry-invalidate strobe.
- inv_index  out  N  entry being invalidated.
- flush_busy  out  1  high while the invalidate walk is in progress.
- lookup_stall  out  1  fetch must treat BTB lookups as misses; equals flush_busy.
- occupancy  out  $clog2(DEPTH)+1  number of queued entries.

## Operation
- **States:** RUN and FLUSH.
- **Reset values:** state RUN, queue empty, inv_index 0. Outputs: res_ready 1; upd_valid, inv_valid, flush_busy, lookup_stall 0; occupancy 0; upd_* all 0.
- **Enqueue:** the queue is written on res_valid && res_ready. The write pointer and read pointer each have $clog2(DEPTH) bits and wrap naturally. The count register tracks fullness.
- **Dequeue:** in RUN, upd_valid = !empty and upd_* show the head entry combinationally.
  - The BTB always accepts a write; there is no backpressure.
  - The head pops on every cycle in which upd_valid is high.
- **Simultaneous push and pop:** occupancy is unchanged. This is allowed when the queue is full only in the sense that ready is low, so no push occurs.
- **RUN -> FLUSH:** taken on flush_req while in RUN.
  - All queued entries are discarded: pointers and count are cleared.
  - A resolution accepted in the same cycle as flush_req is also discarded.
  - inv_index is cleared to 0.
- **In FLUSH:**
  - inv_valid = 1; inv_index increments by 1 per cycle.
  - res_ready = 0 and upd_valid = 0.
  - flush_busy = 1 and lookup_stall = 1.
  - flush_req is ignored.
- **FLUSH -> RUN:** taken on the cycle inv_index == 2**N-1. inv_index returns to 0.
- **Reset mid-flush:** reset returns the block immediately to the reset values; no partial walk resumes.

## Timing
- Enqueue-to-write latency is 1 cycle. An entry accepted at edge t drives upd_valid during cycle t+1 if the queue was empty.
- Throughput is one BTB write per cycle and one accepted resolution per cycle.
- Flush duration is exactly 2**N cycles with inv_valid high, starting the cycle after flush_req is sampled. res_ready rises in the following cycle.
- occupancy and flush_busy are registered outputs. res_ready and upd_valid are combinational from registered state only; they never depend on res_valid or flush_req.

## Configuration
- Macro: BP_UPD_FILTER_EN.
- **Defined:**
  - A resolution with res_mispred=0 and res_taken=0 is handshaken (res_ready unaffected) but not enqueued; occupancy does not change.
  - All other resolutions enqueue normally.
- **Not defined:** every accepted resolution is enqueued.

## Test plan
- **Reset:** release rst with no traffic -> res_ready=1, upd_valid=0, inv_valid=0, occupancy=0, flush_busy=0.
- **Single update:** one push with pc=0x100, target=0x240, taken=1, mispred=1 -> next cycle upd_valid=1 with those values; the following cycle upd_valid=0 and occupancy=0.
- **Full / back-to-back pushes (DEPTH=4):** res_valid held for 6 cycles -> all pushes accepted, occupancy never exceeds 1, upd_* follow push order with 1-cycle lag, and pointers wrap past 3 -> 0 correctly.
- **Flush (N=3):** 2 entries queued, then flush_req -> the queued entries never appear on upd_*. inv_valid is high for exactly 8 cycles with inv_index 0..7. flush_busy and lookup_stall are high for the same 8 cycles. res_ready=0 throughout and returns to 1 the next cycle.
- **Flush boundaries:**
  - flush_req during FLUSH -> ignored, walk length stays 8.
  - rst asserted at inv_index=4 -> all outputs at reset values immediately.
- **Filter (BP_UPD_FILTER_EN defined):** push mispred=0, taken=0 -> res_ready=1, upd_valid stays 0, occupancy 0. Push mispred=0, taken=1 -> written next cycle. Without the macro, both pushes are written.

Source files
------------

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - in-order branch resolution queue feeding BTB writes, plus full-BTB invalidate walk
// Optional macro BP_UPD_FILTER_EN: drop not-taken, correctly predicted resolutions instead of queueing them.
module bp_update_ctrl #(
  parameter int N     = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [31:0]              res_pc,
  input  logic [31:0]              res_target,
  input  logic                     res_taken,
  input  logic                     res_mispred,
  input  logic                     flush_req,
  output logic                     upd_valid,
  output logic [31:0]              upd_pc,
  output logic [31:0]              upd_target,
  output logic                     upd_taken,
  output logic                     upd_mispred,
  output logic                     inv_valid,
  output logic [N-1:0]             inv_index,
  output logic                     flush_busy,
  output logic                     lookup_stall,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [N-1:0] LAST_IDX = '1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [31:0] pc_mem     [DEPTH];
  logic [31:0] target_mem [DEPTH];
  logic        taken_mem  [DEPTH];
  logic        mispred_mem[DEPTH];

  logic accept;
  logic push;
  logic pop;

  assign res_ready = (state == RUN) && (count != FULL_CNT);
  assign upd_valid = (state == RUN) && (count != '0);
  assign accept    = res_valid && res_ready;
  assign pop       = upd_valid;

`ifdef BP_UPD_FILTER_EN
  // A correctly predicted fall-through teaches the BTB nothing, so it is acknowledged and dropped.
  assign push = accept && (res_taken || res_mispred);
`else
  assign push = accept;
`endif

  assign upd_pc       = upd_valid ? pc_mem[rd_ptr]      : '0;
  assign upd_target   = upd_valid ? target_mem[rd_ptr]  : '0;
  assign upd_taken    = upd_valid ? taken_mem[rd_ptr]   : 1'b0;
  assign upd_mispred  = upd_valid ? mispred_mem[rd_ptr] : 1'b0;

  assign flush_busy   = (state == FLUSH);
  assign lookup_stall = flush_busy;
  assign inv_valid    = flush_busy;
  assign occupancy    = count;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]      <= res_pc;
      target_mem[wr_ptr]  <= res_target;
      taken_mem[wr_ptr]   <= res_taken;
      mispred_mem[wr_ptr] <= res_mispred;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      inv_index <= '0;
    end else begin
      case (state)
        RUN: begin
          if (flush_req) begin
            // Anything queued or arriving this cycle predates the fence and is discarded.
            state     <= FLUSH;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            inv_index <= '0;
          end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
          end
        end
        FLUSH: begin
          if (inv_index == LAST_IDX) begin
            state     <= RUN;
            inv_index <= '0;
          end else begin
            inv_index <= inv_index + N'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
